// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI4 encodings and instruction-fetch FSM state
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] ARSIZE_4B   = 3'b010;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_ADDR,
    FETCH_DATA,
    FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - instruction buffer FIFO with flush and occupancy count
module ifetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head_valid = (count != '0);
  // Storage is not reset, so the head is forced to zero while empty.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/axi_ifetch_master.sv
// rtl/axi_ifetch_master.sv - AXI4 instruction-fetch read master with redirect and drain
module axi_ifetch_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FETCH_ID   = 0,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_err,
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic [1:0]            M_AXI_arlock,
  output logic [3:0]            M_AXI_arcache,
  output logic [2:0]            M_AXI_arprot,
  output logic [3:0]            M_AXI_arqos,
  output logic [3:0]            M_AXI_arregion,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  localparam int CW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [10:0] BURST_LEN_W = 11'(BURST_LEN);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] beat_pc;
  logic                  discard;
  logic [10:0]           words_left;
  logic [4:0]            beats;
  logic                  room_ok;
  logic                  ar_hs;
  logic                  push;
  logic                  pop;
  logic [CW:0]           fifo_count;
  logic                  unused_sig;

  assign M_AXI_arid     = ID_WIDTH'(FETCH_ID);
  assign M_AXI_arsize   = ARSIZE_4B;
  assign M_AXI_arburst  = BURST_INCR;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_arcache  = 4'b0011;
  assign M_AXI_arprot   = 3'b100;
  assign M_AXI_arqos    = 4'h0;
  assign M_AXI_arregion = 4'h0;
  assign unused_sig     = ^{M_AXI_rid, redirect_pc[1:0]};

  // Burst is clipped so it never runs past the end of the current 4 KB page.
  assign words_left = 11'd1024 - {1'b0, fetch_pc[11:2]};
  assign beats      = (words_left < BURST_LEN_W) ? words_left[4:0] : BURST_LEN_W[4:0];
  assign room_ok    = (FIFO_DEPTH - int'(fifo_count)) >= int'(beats);
  assign ar_hs      = M_AXI_arvalid && M_AXI_arready;
  assign pop        = instr_valid && instr_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= FETCH_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:  if (!redirect_valid && room_ok) state_nxt = FETCH_ADDR;
      FETCH_ADDR:  if (M_AXI_arready) state_nxt = (redirect_valid || discard) ? FETCH_DRAIN : FETCH_DATA;
      FETCH_DATA: begin
        if (M_AXI_rvalid && M_AXI_rlast) state_nxt = FETCH_IDLE;
        else if (redirect_valid)         state_nxt = FETCH_DRAIN;
      end
      FETCH_DRAIN: if (M_AXI_rvalid && M_AXI_rlast) state_nxt = FETCH_IDLE;
      default:     state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    push          = 1'b0;
    case (state)
      FETCH_ADDR:  M_AXI_arvalid = 1'b1;
      FETCH_DATA: begin
        M_AXI_rready = 1'b1;
        push         = M_AXI_rvalid && !redirect_valid;
      end
      FETCH_DRAIN: M_AXI_rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      fetch_pc     <= RESET_PC;
      beat_pc      <= '0;
      M_AXI_araddr <= '0;
      M_AXI_arlen  <= '0;
      discard      <= 1'b0;
    end else begin
      if (state == FETCH_IDLE && state_nxt == FETCH_ADDR) begin
        M_AXI_araddr <= fetch_pc;
        M_AXI_arlen  <= 8'(beats - 5'd1);
      end
      if (redirect_valid)
        fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (ar_hs && !discard)
        fetch_pc <= fetch_pc + ADDR_WIDTH'({M_AXI_arlen + 8'd1, 2'b00});
      if (ar_hs)     beat_pc <= M_AXI_araddr;
      else if (push) beat_pc <= beat_pc + ADDR_WIDTH'(4);
      // A redirect seen while the address is still pending turns that burst into a drain.
      discard <= (state == FETCH_ADDR) && !M_AXI_arready && (discard || redirect_valid);
    end
  end

  ifetch_fifo #(
    .WIDTH (DATA_WIDTH + ADDR_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({M_AXI_rdata, beat_pc, M_AXI_rresp != RESP_OKAY}),
    .pop        (pop),
    .head_data  ({instr_data, instr_pc, instr_err}),
    .head_valid (instr_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_axi_ifetch_master.sv
// tb/tb_axi_ifetch_master.sv - randomized bench against a sequential-fetch reference model
`timescale 1ns/1ps
module tb_axi_ifetch_master;
  import axi_pkg::*;

  localparam int          BL     = 4;
  localparam logic [31:0] ERR_PC = 32'h8;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESETN = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0, instr_err;
  logic [31:0] instr_data, instr_pc;
  logic [3:0]  M_AXI_arid, M_AXI_arcache, M_AXI_arqos, M_AXI_arregion;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize, M_AXI_arprot;
  logic [1:0]  M_AXI_arburst, M_AXI_arlock;
  logic        M_AXI_arvalid, M_AXI_rready;
  logic        M_AXI_arready = 1'b0;
  logic [3:0]  M_AXI_rid = '0;
  logic [31:0] M_AXI_rdata = '0;
  logic [1:0]  M_AXI_rresp = '0;
  logic        M_AXI_rlast = 1'b0;
  logic        M_AXI_rvalid = 1'b0;

  axi_ifetch_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_err(instr_err),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock),
    .M_AXI_arcache(M_AXI_arcache), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_arregion(M_AXI_arregion), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  function automatic logic [7:0] exp_len(input logic [31:0] a);
    int room;
    room = (4096 - int'(a & 32'hFFF)) / 4;
    return 8'(((room < BL) ? room : BL) - 1);
  endfunction

  // Reference model: a program-order stream of words and AR addresses, rebased on redirect.
  logic [31:0] exp_ar = '0, exp_pc = '0, cap_addr = '0;
  bit          stale = 0, arvalid_prev = 0;
  int          ar_count = 0, r_count = 0, out_count = 0, err_count = 0;
  logic [31:0] last_pc = '0, last_data = '0, last_ar_addr = '0;
  logic [7:0]  last_ar_len = '0;
  bit          burst_active = 0, rvalid_hold = 0;
  logic [31:0] b_addr = '0, beat_addr = '0;
  int          b_len = 0, b_beat = 0;

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_arready = 1'b0;
        M_AXI_rvalid  = 1'b0;
        M_AXI_rlast   = 1'b0;
      end else begin
        M_AXI_arready = ($urandom_range(0, 3) != 0);
        if (!rvalid_hold) begin
          if (burst_active && $urandom_range(0, 3) != 0) begin
            beat_addr    = b_addr + 32'(b_beat * 4);
            M_AXI_rvalid = 1'b1;
            M_AXI_rdata  = rom_word(beat_addr);
            M_AXI_rresp  = (beat_addr == ERR_PC) ? RESP_SLVERR : RESP_OKAY;
            M_AXI_rlast  = (b_beat == b_len);
          end else begin
            M_AXI_rvalid = 1'b0;
          end
        end
      end
      #2;
      if (!ARESETN) begin
        exp_ar = '0; exp_pc = '0; stale = 0; arvalid_prev = 0;
        burst_active = 0; rvalid_hold = 0;
        M_AXI_rvalid = 1'b0; M_AXI_arready = 1'b0;
      end else begin
        if (M_AXI_arvalid && !arvalid_prev) begin
          cap_addr = exp_ar;
          stale = 0;
        end
        if (M_AXI_arvalid && M_AXI_arready) begin
          chk("ar_addr", M_AXI_araddr, cap_addr);
          chk("ar_len", M_AXI_arlen, exp_len(cap_addr));
          chk("ar_attr", {M_AXI_arid, M_AXI_arsize, M_AXI_arburst, M_AXI_arlock, M_AXI_arcache,
                          M_AXI_arprot, M_AXI_arqos, M_AXI_arregion},
                         {4'h0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b100, 4'h0, 4'h0});
          ar_count++;
          last_ar_addr = M_AXI_araddr;
          last_ar_len  = M_AXI_arlen;
          if (!stale && !redirect_valid)
            exp_ar = cap_addr + 32'((int'(exp_len(cap_addr)) + 1) * 4);
          burst_active = 1; b_addr = M_AXI_araddr; b_len = int'(M_AXI_arlen); b_beat = 0;
        end
        if (M_AXI_rvalid && M_AXI_rready) begin
          r_count++;
          rvalid_hold = 0;
          if (b_beat == b_len) burst_active = 0;
          else b_beat++;
        end else if (M_AXI_rvalid) begin
          rvalid_hold = 1;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          chk("out_pc", instr_pc, exp_pc);
          chk("out_data", instr_data, rom_word(exp_pc));
          chk("out_err", instr_err, exp_pc == ERR_PC);
          out_count++;
          if (instr_err) err_count++;
          last_pc = instr_pc; last_data = instr_data;
          exp_pc += 32'd4;
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'd3;
          exp_ar = redirect_pc & ~32'd3;
          if (M_AXI_arvalid && !M_AXI_arready) stale = 1;
        end
        arvalid_prev = M_AXI_arvalid;
      end
    end
  end

  function automatic int cnt_of(input int which);
    case (which)
      0:       return ar_count;
      1:       return r_count;
      default: return out_count;
    endcase
  endfunction

  task automatic wait_for(input int which, input int delta, input int budget, input string tag);
    int base = cnt_of(which);
    int n = 0;
    while (cnt_of(which) < base + delta && n < budget) begin
      @(negedge ACLK); #3;
      n++;
    end
    chk(tag, cnt_of(which) >= base + delta, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, M_AXI_arvalid, 0);
    chk({tag, "_rready"}, M_AXI_rready, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr_data"}, instr_data, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_instr_err"}, instr_err, 0);
    chk({tag, "_araddr"}, M_AXI_araddr, 0);
    chk({tag, "_arlen"}, M_AXI_arlen, 0);
  endtask

  task automatic apply_reset();
    @(negedge ACLK); ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(negedge ACLK); redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge ACLK); redirect_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK); instr_ready = 1'b1;
    end
    @(negedge ACLK); instr_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [31:0] tgt;

    repeat (3) @(negedge ACLK);
    #3 check_reset_outputs("rst");
    @(negedge ACLK); ARESETN = 1'b1;

    instr_ready = 1'b1;
    wait_for(2, 12, 400, "seq_outputs");

    instr_ready = 1'b0;
    apply_reset();
    base = ar_count;
    repeat (80) @(negedge ACLK);
    #3;
    chk("bp_two_bursts", ar_count - base, 2);
    chk("bp_head_valid", instr_valid, 1);
    chk("bp_head_pc", instr_pc, 0);
    n = err_count;
    pop_n(3);
    repeat (40) @(negedge ACLK);
    #3;
    chk("bp_no_third_burst", ar_count - base, 2);
    chk("slverr_seen_once", err_count - n, 1);
    pop_n(1);
    wait_for(0, 1, 60, "bp_third_burst");

    apply_reset();
    wait_for(1, 1, 100, "rd_beat0");
    pulse_redirect(32'h40);
    instr_ready = 1'b1;
    wait_for(2, 1, 200, "rd_first_out");
    chk("rd_first_pc", last_pc, 32'h40);
    chk("rd_first_data", last_data, 32'h110);

    instr_ready = 1'b0;
    repeat (60) @(negedge ACLK);
    pulse_redirect(32'hFF8);
    instr_ready = 1'b1;
    wait_for(0, 1, 100, "pg_ar1");
    chk("pg_ar1_addr", last_ar_addr, 32'hFF8);
    chk("pg_ar1_len", last_ar_len, 1);
    wait_for(0, 1, 100, "pg_ar2");
    chk("pg_ar2_addr", last_ar_addr, 32'h1000);
    chk("pg_ar2_len", last_ar_len, 3);

    n = 0;
    while (!M_AXI_rready && n < 200) begin
      @(negedge ACLK); #3;
      n++;
    end
    chk("mid_reset_in_data", M_AXI_rready, 1);
    ARESETN = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    wait_for(2, 1, 200, "mid_restart_out");
    chk("mid_restart_pc", last_pc, 0);

    base = out_count;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      instr_ready = ($urandom_range(0, 3) != 0);
      if (!redirect_valid && $urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       tgt = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
          1:       tgt = 32'h1000 * $urandom_range(1, 3) - 32'd4 * $urandom_range(1, 5);
          default: tgt = $urandom;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge ACLK); redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (50) @(negedge ACLK);
    #3 chk("rand_progress", (out_count - base) > 200, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_ifetch_master.md
# axi_ifetch_master

Instruction-fetch AXI4 read master that sits directly upstream of the instruction-memory ROM slave and feeds decoded-ready words to the core front end. It fetches sequential INCR bursts starting at a program counter, buffers returned words in a small FIFO, and restarts on a core redirect. Outstanding beats from a redirected burst are drained and discarded.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, instruction word width; fixed at 32
- ID_WIDTH, 4, AXI ID width
- FETCH_ID, 0, value driven on M_AXI_arid
- BURST_LEN, 4, beats per burst (1..16, power of two)
- FIFO_DEPTH, 8, instruction buffer entries (power of two, ≥ BURST_LEN)
- RESET_PC, 0, fetch address after reset
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous, active-low reset
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core consumes head
- instr_data  out  32  instruction word
- instr_pc  out  ADDR_WIDTH  byte address of instr_data
- instr_err  out  1  word returned with rresp ≠ OKAY
- M_AXI_arid/araddr/arlen/arsize/arburst/arlock(2)/arcache/arprot/arqos/arregion/arvalid  out  AR channel
- M_AXI_arready  in  1
- M_AXI_rid, rdata, rresp, rlast, rvalid  in  R channel
- M_AXI_rready  out  1

## Operation
- Constants: arsize=3'b010, arburst=INCR, arlock=0, arcache=4'b0011, arprot=3'b100, arqos=0, arregion=0.
- FSM: IDLE, ADDR, DATA, DRAIN. One burst outstanding at most.
- IDLE: when free = FIFO_DEPTH − count ≥ beats of next burst, go ADDR; araddr = fetch_pc, arlen = beats−1.
- beats = min(BURST_LEN, (4096 − fetch_pc[11:0])/4); never cross a 4 KB boundary.
- ADDR: arvalid=1, address/len stable until arready; on handshake → DATA, fetch_pc += beats*4.
- DATA: rready=1 (space pre-reserved). Each beat pushes {rdata, beat_pc, rresp≠0}; beat_pc += 4. rlast → IDLE.
- Redirect: clears FIFO, fetch_pc = {redirect_pc[ADDR_WIDTH-1:2],2'b00}. In IDLE/ADDR-after-handshake-none: stay/return IDLE (ADDR with arvalid high must complete its handshake, then DRAIN). In DATA → DRAIN.
- DRAIN: rready=1, beats discarded, on rlast → IDLE.
- Redirect in same cycle as rlast in DATA: beat discarded, go IDLE.
- Redirect same cycle as instr pop: redirect wins, FIFO empty next cycle.
- rid not checked; rlast trusted, beat count not enforced.

## Timing
- Reset values: arvalid=0, rready=0, instr_valid=0, instr_data=0, instr_pc=0, instr_err=0, araddr=0, arlen=0; fetch_pc=RESET_PC, state IDLE.
- First arvalid 2 cycles after ARESETN deassert (IDLE→ADDR, registered).
- redirect_valid at cycle N (from IDLE) → arvalid at N+2 with new address.
- R beat accepted at N → instr_valid at N+1 (registered FIFO).
- FIFO: simultaneous push and pop allowed when full−? No overfill possible by reservation; push into empty with pop same cycle illegal (head not yet valid).
- ARESETN low mid-burst: all state cleared asynchronously; slave is reset by same net.

## Structure
- Package axi_pkg: BURST_INCR, RESP_OKAY/SLVERR, ARSIZE_4B, fetch FSM state typedef.
- Sub-module ifetch_fifo: synchronous FIFO, width 32+ADDR_WIDTH+1, depth FIFO_DEPTH, flush input, count output.

## Test plan
- Reset, ROM word[i]=0x100+i, instr_ready=1 → AR araddr=0x0 arlen=3, then 0x10; outputs (0x100,pc 0),(0x101,pc 4)… in order.
- instr_ready=0 → exactly 2 bursts issued, FIFO holds 8, no third arvalid until a pop leaves ≥4 free.
- redirect_pc=0x40 during beat 1 of burst at 0x0 → beats 2–3 discarded, next araddr=0x40, first output pc 0x40 data 0x110.
- redirect_pc=0xFF8 → arlen=1 at 0xFF8, next burst araddr=0x1000 arlen=3.
- Slave returns rresp=SLVERR on beat 2 → that word instr_err=1, others 0, fetch continues.
- ARESETN low during DATA → all outputs reset values same cycle; after release restart at RESET_PC.
